// File: rtl/div_radix2.sv
// div_radix2: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle on operand magnitudes. Signs are re-applied
// when the result is loaded. A zero divisor finishes immediately with a zero result.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic               i_start,
   input  logic               i_signed_div,
   input  logic               i_annul,
   output logic               o_stall,
   output logic               o_ready,
   output logic [2*WIDTH-1:0] o_result
);

   localparam int               CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Two's-complement negate when requested; used for magnitudes and sign fix-up.
   function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] val,
                                                 input logic             neg);
      logic [WIDTH-1:0] res;
      if (neg) begin
         res = ZERO_W - val;
      end else begin
         res = val;
      end
      return res;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   // Only the low WIDTH bits of the partial remainder are stored. After every
   // restoring step the remainder is below the divisor, so the top bit is always 0.
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [WIDTH-1:0]   r_dvs;
   logic [WIDTH-1:0]   w_dvs_nxt;
   logic               r_neg_q;
   logic               w_neg_q_nxt;
   logic               r_neg_r;
   logic               w_neg_r_nxt;
   logic [2*WIDTH-1:0] r_result;
   logic [2*WIDTH-1:0] w_result_nxt;
   logic               r_ready;
   logic               w_ready_nxt;

   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH:0]     w_rem_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_rem_step;
   logic [WIDTH-1:0]   w_quo_step;

   assign w_sign_a = i_signed_div & i_a[WIDTH-1];
   assign w_sign_b = i_signed_div & i_b[WIDTH-1];

   // The ALU is held while a requested division is not yet finished, unless it is being flushed.
   assign o_stall  = i_start & ~r_ready & ~i_annul;
   assign o_ready  = r_ready;
   assign o_result = r_result;

   // Restoring step: shift in the next dividend bit and keep the trial subtraction when it is non-negative.
   always_comb begin
      w_rem_shift = {r_rem, r_quo[WIDTH-1]};
      w_trial     = w_rem_shift - {1'b0, r_dvs};
      w_quo_step  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
      if (w_trial[WIDTH]) begin
         w_rem_step = w_rem_shift[WIDTH-1:0];
      end else begin
         w_rem_step = w_trial[WIDTH-1:0];
      end
   end

   // Next-state and datapath-load decode. Annul overrides every state.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_quo_nxt    = r_quo;
      w_dvs_nxt    = r_dvs;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_result_nxt = r_result;
      w_ready_nxt  = 1'b0;

      if (i_annul) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  w_quo_nxt   = f_neg_if(i_a, w_sign_a);
                  w_dvs_nxt   = f_neg_if(i_b, w_sign_b);
                  w_neg_r_nxt = w_sign_a;
                  w_neg_q_nxt = w_sign_a ^ w_sign_b;
                  w_cnt_nxt   = CNT_ZERO;
                  w_rem_nxt   = ZERO_W;
                  if (i_b == ZERO_W) begin
                     w_state_nxt  = S_DONE;
                     w_ready_nxt  = 1'b1;
                     w_result_nxt = {2*WIDTH{1'b0}};
                  end else begin
                     w_state_nxt = S_ON;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ON: begin
               w_rem_nxt = w_rem_step;
               w_quo_nxt = w_quo_step;
               w_cnt_nxt = r_cnt + CNT_ONE;
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt  = S_DONE;
                  w_ready_nxt  = 1'b1;
                  w_result_nxt = {f_neg_if(w_rem_step, r_neg_r),
                                  f_neg_if(w_quo_step, r_neg_q)};
               end else begin
                  w_state_nxt = S_ON;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers. A synchronous reset clears everything, including the held result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= CNT_ZERO;
         r_rem    <= ZERO_W;
         r_quo    <= ZERO_W;
         r_dvs    <= ZERO_W;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= {2*WIDTH{1'b0}};
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
         r_dvs    <= w_dvs_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

endmodule

// File: doc/div_radix2.md
# div_radix2

Multi-cycle radix-2 restoring divider for MIPS `DIV`/`DIVU`. It sits directly upstream of the execute-stage ALU. The ALU drives `start`/`signed_div` from its op decode and holds the pipeline on `stall`. On completion the ALU forwards `result` unchanged to its HI/LO output as `{HI = remainder, LO = quotient}`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is verified.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `a`  in  32  dividend (rs); sampled only in the start cycle.
- `b`  in  32  divisor (rt); sampled only in the start cycle.
- `start`  in  1  division requested; level, held by the ALU while the DIV op is in EX.
- `signed_div`  in  1  1 = `DIV` (two's complement), 0 = `DIVU`; sampled with `start`.
- `annul`  in  1  exception/flush; aborts any division in progress.
- `stall`  out  1  combinational: `start & ~ready & ~annul`.
- `ready`  out  1  registered; high exactly one cycle (state DONE).
- `result`  out  64  `{remainder[31:0], quotient[31:0]}`; registered, held until the next completion.

## Operation
- States: IDLE, ON, DONE.
- IDLE:
  - With `start & ~annul`, latch `|a|`, `|b|`, the sign of `a`, `sign(a)^sign(b)` (signs forced to 0 when `signed_div=0`), and clear `cnt` (5 bits) and the 33-bit partial remainder `R`.
  - If `b==0`, go to DONE with next `result = 64'h0`. Otherwise go to ON.
- ON, one step per cycle:
  - `R' = {R[31:0], Q[31]}`, `Q <<= 1`.
  - `T = R' - {1'b0,|b|}`.
  - If `T[32]==0`: `R = T`, `Q[0] = 1`. Else: `R = R'`, `Q[0] = 0`.
  - `cnt++`. The step with `cnt==31` moves to DONE.
  - At that transition, `result` loads the sign-corrected values:
    - quotient negated if the sign-xor flag is set;
    - remainder negated if the dividend sign is set (remainder takes the dividend's sign).
- DONE: `ready=1`, go to IDLE unconditionally.
  - A `start` still high in the following IDLE cycle begins a new division. The ALU is responsible for dropping `start` once its instruction advances.
- Overflow case: signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0 (natural wrap, no trap).
- `annul`:
  - In any state, the next state is IDLE and `ready` stays 0.
  - `result` is not updated.
  - `stall` is forced low in the same cycle.
- `rst`: state IDLE, `cnt=0`, `R=0`, `Q=0`, `result=64'h0`, `ready=0`. `stall` then follows `start` (high if `start` is held).
- `a`/`b`/`signed_div` changing during ON have no effect.

## Timing
- The start cycle (IDLE with `start`) is cycle 0.
- Non-zero divisor:
  - ON occupies cycles 1..32.
  - DONE and valid `result` in cycle 33.
  - `stall` high in cycles 0..32 and low in cycle 33.
  - Total occupancy 34 cycles.
- Zero divisor: DONE in cycle 1. `stall` high only in cycle 0.
- `result` changes only on the edge entering DONE. It is stable from then until the next entry to DONE.
- Back-to-back divisions: the next earliest start cycle is the cycle after DONE.
- `annul` during cycle k: state is IDLE at k+1.
  - `start` at k+1 with `annul` low begins a fresh division with full latency.
- `rst` has priority over `annul`, and `annul` has priority over `start`.

## Test plan
- DIVU `a=100, b=7`, start held → `stall` high in cycles 0..32; `ready` and `result=64'h00000002_0000000E` in cycle 33; `stall` low in cycle 33.
- DIV `a=-7 (0xFFFFFFF9), b=2` → `result=64'hFFFFFFFF_FFFFFFFD`. DIV `a=7, b=-2` → `64'h00000001_FFFFFFFD`.
- DIV `a=0x80000000, b=0xFFFFFFFF` → `64'h00000000_80000000`. DIVU `a=0xFFFFFFFF, b=1` → `64'h00000000_FFFFFFFF`. DIVU `a=3, b=10` → `64'h00000003_00000000`.
- `b=0`, DIVU `a=5` → `ready` in cycle 1, `result=0`, `stall` high only in cycle 0.
- `annul` in cycle 10 of `100/7` after a prior result `R0` → IDLE in cycle 11, no `ready`, `result` stays `R0`. A new start of `50/5` in cycle 11 yields `64'h00000000_0000000A` 33 cycles later.
- `rst` asserted in cycle 20 of a division → all registers cleared next cycle, `result=0`, no `ready`. Back-to-back `9/2` then `20/6` complete in cycles 33 and 67.
